debounce_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-button debouncer: CHANNELS independent push-button/switch inputs.
- Each channel has a 2-FF synchroniser, a per-channel stability counter, a debounced level output, and one-cycle rise/fall pulses.
- Adds an asynchronous active-high reset, a configurable reset level, and a counter-advance enable that allows a shared prescaler tick.
- Sits between board buttons/switches and the control FSMs.

---
 rtl/debounce_multi.sv | 62 ++++++
 tb/tb_debounce_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel push-button/switch debouncer: per channel a 2-FF synchroniser,
// a stability counter gated by ce, a debounced level and registered rise/fall pulses.
module debounce_multi #(
    parameter int   CHANNELS      = 4,
    parameter int   CNT_WIDTH     = 20,
    parameter int   STABLE_CYCLES = 1000000,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] result,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    // Last count value before acceptance; the counter clears on reaching it, so it never wraps.
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0]  s0;
    logic [CHANNELS-1:0]  s1;
    logic [CNT_WIDTH-1:0] cnt [CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0     <= {CHANNELS{INIT_LEVEL}};
            s1     <= {CHANNELS{INIT_LEVEL}};
            result <= {CHANNELS{INIT_LEVEL}};
            rise   <= '0;
            fall   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s0 <= button;
            s1 <= s0;
            for (int i = 0; i < CHANNELS; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                if (s1[i] != result[i]) begin
                    if (ce) begin
                        if (cnt[i] == LAST) begin
                            result[i] <= s1[i];
                            cnt[i]    <= '0;
                            rise[i]   <= s1[i];
                            fall[i]   <= ~s1[i];
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign any_change = |{rise, fall};

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: one low-idle instance and one high-idle
// instance sharing clock, reset and ce.
module tb_debounce_multi;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic [W-1:0] button;
    logic [W-1:0] button_hi;
    logic [W-1:0] result, rise, fall;
    logic         any_change;
    logic [W-1:0] result_hi, rise_hi, fall_hi;
    logic         any_change_hi;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS(W), .CNT_WIDTH(4), .STABLE_CYCLES(4), .INIT_LEVEL(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .button(button),
        .result(result), .rise(rise), .fall(fall), .any_change(any_change)
    );

    debounce_multi #(
        .CHANNELS(W), .CNT_WIDTH(4), .STABLE_CYCLES(4), .INIT_LEVEL(1'b1)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .ce(ce), .button(button_hi),
        .result(result_hi), .rise(rise_hi), .fall(fall_hi), .any_change(any_change_hi)
    );

    // Drive a new button pattern and let 8 edges pass so any acceptance completes.
    task automatic settle(input logic [W-1:0] b);
        @(negedge clk);
        button = b;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        // power-on state right after the initial release
        tests++;
        if ({result, rise, fall, any_change} !== 13'd0) begin
            failed++;
            $display("FAIL reset_initial: got %b want %b", {result, rise, fall, any_change}, 13'd0);
        end
        tests++;
        if ({result_hi, rise_hi, fall_hi, any_change_hi} !== {4'hF, 9'd0}) begin
            failed++;
            $display("FAIL reset_initial_hi: got %b want %b",
                     {result_hi, rise_hi, fall_hi, any_change_hi}, {4'hF, 9'd0});
        end
        settle(4'hF);
        tests++;
        if (result !== 4'hF) begin
            failed++;
            $display("FAIL reset_preload: got %b want 1111", result);
        end
        // asynchronous assertion in the middle of the low clock phase
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({result, rise, fall, any_change} !== 13'd0) begin
            failed++;
            $display("FAIL reset_async: got %b want %b", {result, rise, fall, any_change}, 13'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_v = {(k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0, k == 6};
            tests++;
            if ({result, rise, fall, any_change} !== exp_v) begin
                failed++;
                $display("FAIL reset_requalify k=%0d: got %b want %b",
                         k, {result, rise, fall, any_change}, exp_v);
            end
        end
        settle(4'h0);
    endtask

    task automatic test_clean_press();
        logic [12:0] exp_v;
        @(negedge clk);
        button[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_v = {(k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 4'h0, k == 6};
            tests++;
            if ({result, rise, fall, any_change} !== exp_v) begin
                failed++;
                $display("FAIL clean_press k=%0d: got %b want %b",
                         k, {result, rise, fall, any_change}, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        logic [12:0] exp_v;
        @(negedge clk);
        button[1] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_v = {(k >= 14) ? 4'b0011 : 4'b0001, (k == 14) ? 4'b0010 : 4'b0000, 4'h0, k == 14};
            tests++;
            if ({result, rise, fall, any_change} !== exp_v) begin
                failed++;
                $display("FAIL bounce k=%0d: got %b want %b",
                         k, {result, rise, fall, any_change}, exp_v);
            end
            if (k == 2 || k == 6) button[1] = 1'b0;
            if (k == 4 || k == 8) button[1] = 1'b1;
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        button[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tests++;
            if ({result, rise, fall, any_change} !== {4'b0011, 9'd0}) begin
                failed++;
                $display("FAIL glitch k=%0d: got %b want %b",
                         k, {result, rise, fall, any_change}, {4'b0011, 9'd0});
            end
            if (k == 3) button[2] = 1'b0;
        end
    endtask

    task automatic test_prescale();
        logic [12:0] exp_v;
        @(negedge clk);
        button[3] = 1'b1;
        ce = 1'b0;
        // ce is high before edges 3, 6, 9, 12; mismatch is visible from edge 3
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_v = {(k >= 12) ? 4'b1011 : 4'b0011, (k == 12) ? 4'b1000 : 4'b0000, 4'h0, k == 12};
            tests++;
            if ({result, rise, fall, any_change} !== exp_v) begin
                failed++;
                $display("FAIL prescale k=%0d: got %b want %b",
                         k, {result, rise, fall, any_change}, exp_v);
            end
            ce = ((k + 1) % 3 == 0);
        end
        ce = 1'b1;
        settle(4'b0011);
    endtask

    task automatic test_simultaneous_release();
        logic [12:0] exp_v;
        tests++;
        if (result !== 4'b0011) begin
            failed++;
            $display("FAIL simul_pre: got %b want 0011", result);
        end
        @(negedge clk);
        button = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_v = {(k >= 6) ? 4'b0000 : 4'b0011, 4'h0, (k == 6) ? 4'b0011 : 4'b0000, k == 6};
            tests++;
            if ({result, rise, fall, any_change} !== exp_v) begin
                failed++;
                $display("FAIL simul_release k=%0d: got %b want %b",
                         k, {result, rise, fall, any_change}, exp_v);
            end
        end
    endtask

    task automatic test_init_high();
        logic [12:0] exp_v;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++;
            if ({result_hi, rise_hi, fall_hi, any_change_hi} !== {4'hF, 9'd0}) begin
                failed++;
                $display("FAIL init_high_idle k=%0d: got %b want %b",
                         k, {result_hi, rise_hi, fall_hi, any_change_hi}, {4'hF, 9'd0});
            end
        end
        button_hi = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_v = {(k >= 6) ? 4'b1110 : 4'b1111, 4'h0, (k == 6) ? 4'b0001 : 4'b0000, k == 6};
            tests++;
            if ({result_hi, rise_hi, fall_hi, any_change_hi} !== exp_v) begin
                failed++;
                $display("FAIL init_high_release k=%0d: got %b want %b",
                         k, {result_hi, rise_hi, fall_hi, any_change_hi}, exp_v);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        ce        = 1'b1;
        button    = 4'h0;
        button_hi = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_prescale();
        test_simultaneous_release();
        test_init_high();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
